// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-state engine.
// Direction/state encodings, segment coordinate struct, LFSR seed and taps.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_SCAN,
    ST_UPDATE,
    ST_FOOD_PICK,
    ST_FOOD_SCAN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } coord_t;

  localparam logic [31:0] NO_SEG    = 32'hFFFF_FFFF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] pad32(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

endpackage

// File: rtl/snake_food_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to propose food tiles.
// Latency: new value every clock from reset.
// Backpressure: none; consumers sample whenever they need a candidate.
module snake_food_lfsr
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game-state engine: body, direction, food and game-over for the VGA stage.
// Latency: non-growing move lands length+1 cycles after the tick; growth adds scan + food search.
// Backpressure: move_tick is accepted only in IDLE; ticks while busy are dropped.
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 100,
  parameter int GRID_W   = 10,
  parameter int GRID_H   = 10,
  parameter int INIT_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 move_tick,
  input  logic                 dir_valid,
  input  logic [1:0]           dir_in,
  output logic [32*MAX_LEN-1:0] x_values,
  output logic [32*MAX_LEN-1:0] y_values,
  output logic [31:0]          food_x,
  output logic [31:0]          food_y,
  output logic                 game_done,
  output logic [7:0]           length,
  output logic                 busy,
  output logic                 ate
);

  localparam int         IW   = $clog2(MAX_LEN);
  localparam logic [7:0] GW8  = 8'(GRID_W);
  localparam logic [7:0] GH8  = 8'(GRID_H);
  localparam logic [7:0] ML8  = 8'(MAX_LEN);
  localparam logic [7:0] MIDY = 8'(GRID_H / 2);

  state_t        state, state_d;
  dir_t          dir, pending_dir;
  logic [7:0]    x_mem [MAX_LEN];
  logic [7:0]    y_mem [MAX_LEN];
  coord_t        head, nh_c, next_head, cand, cand_c, food;
  logic          grow, off_grid, seg_hit, scan_last, food_hit, food_last, cand_ok;
  logic [IW-1:0] idx;
  logic [7:0]    len_q, scan_limit;
  logic [15:0]   lfsr;

  snake_food_lfsr u_lfsr (.clk(clk), .reset(reset), .lfsr(lfsr));

  always_comb begin
    head     = '{x: x_mem[0], y: y_mem[0]};
    nh_c     = head;
    off_grid = 1'b0;
    // The pending direction is what this move uses; it is committed in EVAL.
    case (pending_dir)
      DIR_UP:    if (head.y == 8'd0)        off_grid = 1'b1; else nh_c.y = head.y - 8'd1;
      DIR_RIGHT: if (head.x == GW8 - 8'd1)  off_grid = 1'b1; else nh_c.x = head.x + 8'd1;
      DIR_DOWN:  if (head.y == GH8 - 8'd1)  off_grid = 1'b1; else nh_c.y = head.y + 8'd1;
      DIR_LEFT:  if (head.x == 8'd0)        off_grid = 1'b1; else nh_c.x = head.x - 8'd1;
      default:   off_grid = 1'b0;
    endcase
    scan_limit = grow ? len_q : len_q - 8'd1;
    scan_last  = (8'(idx) == scan_limit - 8'd1);
    seg_hit    = (x_mem[idx] == next_head.x) && (y_mem[idx] == next_head.y);
    food_hit   = (x_mem[idx] == cand.x) && (y_mem[idx] == cand.y);
    food_last  = (8'(idx) == len_q - 8'd1);
    cand_c     = '{x: {4'd0, lfsr[3:0]}, y: {4'd0, lfsr[7:4]}};
    cand_ok    = (cand_c.x < GW8) && (cand_c.y < GH8);
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:      if (move_tick) state_d = ST_EVAL;
      ST_EVAL:      state_d = off_grid ? ST_DONE : ST_SCAN;
      ST_SCAN:      if (seg_hit) state_d = ST_DONE; else if (scan_last) state_d = ST_UPDATE;
      ST_UPDATE:    if (!grow) state_d = ST_IDLE;
                    else state_d = (len_q + 8'd1 == ML8) ? ST_DONE : ST_FOOD_PICK;
      ST_FOOD_PICK: if (cand_ok) state_d = ST_FOOD_SCAN;
      ST_FOOD_SCAN: if (food_hit) state_d = ST_FOOD_PICK; else if (food_last) state_d = ST_IDLE;
      ST_DONE:      state_d = ST_DONE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      ate       <= 1'b0;
      game_done <= 1'b0;
    end else begin
      state     <= state_d;
      busy      <= !(state_d inside {ST_IDLE, ST_DONE});
      ate       <= (state_d == ST_UPDATE) && grow;
      game_done <= game_done || (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        x_mem[i] <= (i < INIT_LEN) ? 8'(INIT_LEN + 1 - i) : NO_SEG[7:0];
        y_mem[i] <= (i < INIT_LEN) ? MIDY : NO_SEG[7:0];
      end
      dir         <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      len_q       <= 8'(INIT_LEN);
      food        <= '{x: GW8 - 8'd3, y: MIDY};
      next_head   <= '0;
      cand        <= '0;
      grow        <= 1'b0;
      idx         <= '0;
    end else begin
      // A reversal of the committed direction would fold the head into the neck.
      if (dir_valid && (dir_in != (dir ^ 2'b10))) pending_dir <= dir_t'(dir_in);
      case (state)
        ST_EVAL: begin
          dir       <= pending_dir;
          next_head <= nh_c;
          grow      <= (nh_c == food);
          idx       <= '0;
        end
        ST_SCAN: if (!seg_hit && !scan_last) idx <= idx + 1'b1;
        ST_UPDATE: begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            x_mem[i] <= x_mem[i-1];
            y_mem[i] <= y_mem[i-1];
          end
          x_mem[0] <= next_head.x;
          y_mem[0] <= next_head.y;
          if (grow) begin
            len_q <= len_q + 8'd1;
          end else begin
            x_mem[len_q[IW-1:0]] <= NO_SEG[7:0];
            y_mem[len_q[IW-1:0]] <= NO_SEG[7:0];
          end
        end
        ST_FOOD_PICK: if (cand_ok) begin
          cand <= cand_c;
          idx  <= '0;
        end
        ST_FOOD_SCAN: if (!food_hit) begin
          if (food_last) food <= cand;
          else           idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign x_values[32*g +: 32] = pad32(x_mem[g]);
    assign y_values[32*g +: 32] = pad32(y_mem[g]);
  end

  assign food_x = pad32(food.x);
  assign food_y = pad32(food.y);
  assign length = len_q;

endmodule
